// File: rtl/tm1638_frame_seq.sv
// TM1638 frame sequencer: each frame issues display write, brightness and key-scan bytes
// to the serial byte engine over req/ack, snapshotting segments and publishing key bits.
module tm1638_frame_seq #(
    parameter int C_FRAME_CYC = 480_000,
    parameter int C_TMO_CYC   = 4096
) (
    input  logic         CK_i,
    input  logic         XARST_i,
    input  logic         EN_CK_i,
    input  logic [127:0] SEG_DAT_i,
    input  logic [2:0]   BRIGHT_i,
    input  logic         DISP_ON_i,
    output logic         BYTE_REQ_o,
    output logic [7:0]   BYTE_DAT_o,
    output logic         BYTE_RD_o,
    output logic         BYTE_LAST_o,
    input  logic         BYTE_ACK_i,
    input  logic [7:0]   BYTE_RDAT_i,
    output logic [31:0]  KEY_o,
    output logic         KEY_VALID_o,
    output logic         BUSY_o,
    output logic         TMO_ERR_o
);
    localparam int FW = $clog2(C_FRAME_CYC + 1);
    localparam int TW = $clog2(C_TMO_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADR, S_DATA, S_CTRL, S_KCMD, S_KRD, S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [FW-1:0]  frame_cnt;
    logic           pending;
    logic [127:0]   seg_snap;
    logic [2:0]     bright_snap;
    logic           disp_snap;
    logic           req;
    logic [3:0]     idx;
    logic [TW-1:0]  tmo_cnt;
    logic [23:0]    key_shadow;
    logic [31:0]    key;
    logic           key_valid;
    logic           tmo_err;
    logic           tick, start, byte_ack, tmo_hit, in_byte;
    logic [7:0]     dat;
    logic           rd, last;

    always_comb begin
        tick      = (frame_cnt == FW'(C_FRAME_CYC - 1));
        start     = (state == S_IDLE) && (tick || pending);
        byte_ack  = req && BYTE_ACK_i;
        tmo_hit   = req && !BYTE_ACK_i && (tmo_cnt == TW'(C_TMO_CYC - 1));
        in_byte   = (state != S_IDLE) && (state != S_DONE);
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_CMD;
            S_CMD:  if (byte_ack) state_nxt = S_ADR;
            S_ADR:  if (byte_ack) state_nxt = S_DATA;
            S_DATA: if (byte_ack && idx == 4'hF) state_nxt = S_CTRL;
            S_CTRL: if (byte_ack) state_nxt = S_KCMD;
            S_KCMD: if (byte_ack) state_nxt = S_KRD;
            S_KRD:  if (byte_ack && idx[1:0] == 2'd3) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (tmo_hit) state_nxt = S_IDLE;
    end

    // Byte fields are decoded from held state, so they stay stable for the whole request.
    always_comb begin
        dat  = 8'h00;
        rd   = 1'b0;
        last = 1'b0;
        case (state)
            S_CMD:  begin dat = 8'h40; last = 1'b1; end
            S_ADR:  dat = 8'hC0;
            S_DATA: begin dat = seg_snap[{idx, 3'b000} +: 8]; last = (idx == 4'hF); end
            S_CTRL: begin dat = {4'h8, disp_snap, bright_snap}; last = 1'b1; end
            S_KCMD: dat = 8'h42;
            S_KRD:  begin rd = 1'b1; last = (idx[1:0] == 2'd3); end
            default: ;
        endcase
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i)     state <= S_IDLE;
        else if (EN_CK_i) state <= state_nxt;
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            frame_cnt   <= '0;
            pending     <= 1'b0;
            seg_snap    <= '0;
            bright_snap <= '0;
            disp_snap   <= 1'b0;
            req         <= 1'b0;
            idx         <= '0;
            tmo_cnt     <= '0;
            key_shadow  <= '0;
            key         <= '0;
            key_valid   <= 1'b0;
            tmo_err     <= 1'b0;
        end else if (EN_CK_i) begin
            frame_cnt <= tick ? '0 : frame_cnt + FW'(1);
            key_valid <= 1'b0;
            tmo_err   <= 1'b0;

            // A tick arriving while busy is remembered once; further ticks are dropped.
            if (start) begin
                pending     <= 1'b0;
                seg_snap    <= SEG_DAT_i;
                bright_snap <= BRIGHT_i;
                disp_snap   <= DISP_ON_i;
            end else if (tick) begin
                pending <= 1'b1;
            end

            if (byte_ack || tmo_hit)  req <= 1'b0;
            else if (in_byte && !req) req <= 1'b1;

            if (!req || byte_ack || tmo_hit) tmo_cnt <= '0;
            else                             tmo_cnt <= tmo_cnt + TW'(1);

            if (tmo_hit)       idx <= '0;
            else if (byte_ack) idx <= (state_nxt != state) ? 4'd0 : idx + 4'd1;

            if (tmo_hit) tmo_err <= 1'b1;

            if (byte_ack && state == S_KRD) begin
                case (idx[1:0])
                    2'd0: key_shadow[7:0]   <= BYTE_RDAT_i;
                    2'd1: key_shadow[15:8]  <= BYTE_RDAT_i;
                    2'd2: key_shadow[23:16] <= BYTE_RDAT_i;
                    default: begin
                        key       <= {BYTE_RDAT_i, key_shadow};
                        key_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign BYTE_REQ_o  = req;
    assign BYTE_DAT_o  = dat;
    assign BYTE_RD_o   = rd;
    assign BYTE_LAST_o = last;
    assign KEY_o       = key;
    assign KEY_VALID_o = key_valid;
    assign BUSY_o      = (state != S_IDLE);
    assign TMO_ERR_o   = tmo_err;
endmodule

// File: tb/tb_tm1638_frame_seq.sv
// Directed bench for tm1638_frame_seq: a behavioural byte engine logs every acknowledged
// byte and answers key reads; the main sequence checks stream, timing and abort behaviour.
module tb_tm1638_frame_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, en;
    logic [127:0] seg;
    logic [2:0]   bright;
    logic         disp;
    logic         req, rd, last, ack, kv, busy, tmo;
    logic [7:0]   dat, rdat;
    logic [31:0]  key;

    tm1638_frame_seq #(.C_FRAME_CYC(100), .C_TMO_CYC(16)) dut (
        .CK_i(clk), .XARST_i(rst_n), .EN_CK_i(en),
        .SEG_DAT_i(seg), .BRIGHT_i(bright), .DISP_ON_i(disp),
        .BYTE_REQ_o(req), .BYTE_DAT_o(dat), .BYTE_RD_o(rd), .BYTE_LAST_o(last),
        .BYTE_ACK_i(ack), .BYTE_RDAT_i(rdat),
        .KEY_o(key), .KEY_VALID_o(kv), .BUSY_o(busy), .TMO_ERR_o(tmo)
    );

    int n_chk = 0, n_pass = 0;
    int ack_dly = 3, wh_pos = -1, en_toggle = 0;
    int cyc = 0, fpos = 0, waitc = 0, log_cnt = 0, kv_cnt = 0, tmo_n = 0, tmo_lat = 0;
    int start_q[$], kv_q[$], tmo_q[$];
    logic [7:0] log_dat [512];
    logic       log_rd  [512];
    logic       log_last[512];
    logic [7:0] key_rsp [4] = '{8'h01, 8'h02, 8'h04, 8'h80};
    logic       en_edge, rst_edge, busy_prev = 1'b0;
    logic [127:0] pat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Engine model: acks ack_dly enabled cycles after REQ, holds ack until an enabled edge.
    initial begin
        ack = 1'b0;
        rdat = 8'h00;
        forever begin
            @(posedge clk);
            en_edge  = en;
            rst_edge = rst_n;
            #1;
            if (!rst_n || !rst_edge) begin
                ack = 1'b0; waitc = 0; fpos = 0; cyc = 0; busy_prev = 1'b0;
            end else if (en_edge) begin
                cyc++;
                if (busy && !busy_prev) start_q.push_back(cyc);
                busy_prev = busy;
                if (kv) begin kv_cnt++; kv_q.push_back(cyc); end
                if (tmo) begin
                    tmo_n++; tmo_q.push_back(cyc); tmo_lat = waitc; fpos = 0; waitc = 0;
                end
                if (ack) ack = 1'b0;
                else if (req) begin
                    waitc++;
                    if (waitc >= ack_dly && fpos != wh_pos) begin
                        log_dat[log_cnt] = dat; log_rd[log_cnt] = rd; log_last[log_cnt] = last;
                        if (log_cnt < 511) log_cnt++;
                        if (rd && fpos >= 20) rdat = key_rsp[fpos-20];
                        ack = 1'b1;
                        waitc = 0;
                        fpos = (fpos == 23) ? 0 : fpos + 1;
                    end
                end else waitc = 0;
            end
            en = (en_toggle != 0) ? ~en : 1'b1;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        log_cnt = 0; kv_cnt = 0; tmo_n = 0;
        start_q.delete(); kv_q.delete(); tmo_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_kv(input int target, input int budget);
        int n = 0;
        while (kv_cnt < target && n < budget) begin @(posedge clk); #2; n++; end
        check($sformatf("kv_reach_%0d", target), 64'(kv_cnt >= target), 64'd1);
    endtask

    task automatic check_frame(input int base, input logic [127:0] segv, input logic [7:0] ctrl);
        logic [9:0] exp, got;
        check($sformatf("frame@%0d_len", base), 64'(log_cnt >= base + 24), 64'd1);
        for (int k = 0; k < 24; k++) begin
            if (k == 0)       exp = {2'b01, 8'h40};
            else if (k == 1)  exp = {2'b00, 8'hC0};
            else if (k < 18)  exp = {1'b0, k == 17, segv[(k-2)*8 +: 8]};
            else if (k == 18) exp = {2'b01, ctrl};
            else if (k == 19) exp = {2'b00, 8'h42};
            else              exp = {1'b1, k == 23, 8'h00};
            got = {log_rd[base+k], log_last[base+k], log_rd[base+k] ? 8'h00 : log_dat[base+k]};
            check($sformatf("frame@%0d_b%0d", base, k), 64'(got), 64'(exp));
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) pat[i*8 +: 8] = {4'(i), 4'(15 - i)};
        rst_n = 1'b0; en = 1'b1; seg = pat; bright = 3'd7; disp = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_out", 64'({req, rd, last, dat, key, kv, busy, tmo}), 64'd0);

        // Basic frame: timing, stream, key word
        do_reset();
        n = 0;
        while (!req && n < 300) begin @(posedge clk); #2; n++; end
        check("first_req_cyc", 64'(n), 64'd101);
        check("first_byte", 64'({rd, last, dat}), 64'({2'b01, 8'h40}));
        wait_kv(1, 400);
        check("kv_cycle", 64'((kv_q.size() > 0) ? kv_q[0] : -1), 64'd196);
        check("key_word", 64'(key), 64'h80040201);
        check("done_kv_busy", 64'({kv, busy}), 64'b11);
        @(posedge clk); #2;
        check("after_done", 64'({kv, busy}), 64'b00);
        check_frame(0, pat, 8'h8F);
        check("kv_single", 64'(kv_cnt), 64'd1);

        // Slow engine: pending tick restarts at once, extra ticks dropped
        ack_dly = 8;
        do_reset();
        wait_kv(2, 700);
        ack_dly = 1;
        wait_kv(4, 300);
        n = 0;
        while (cyc < 699 && n < 200) begin @(posedge clk); #2; n++; end
        check("pend_starts", 64'(start_q.size()), 64'd4);
        check("pend_s1", 64'((start_q.size() > 1) ? start_q[1] : -1), 64'd318);
        check("pend_s2", 64'((start_q.size() > 2) ? start_q[2] : -1), 64'd536);
        check("pend_s3", 64'((start_q.size() > 3) ? start_q[3] : -1), 64'd600);
        check("pend_kv3", 64'((kv_q.size() > 3) ? kv_q[3] : -1), 64'd648);
        check("pend_frames", 64'(kv_cnt), 64'd4);

        // Ack withheld on byte 5 of frame 2
        ack_dly = 3;
        do_reset();
        wait_kv(1, 300);
        wh_pos = 5;
        n = 0;
        while (tmo_n < 1 && n < 300) begin @(posedge clk); #2; n++; end
        wh_pos = -1;
        check("tmo_seen", 64'(tmo_n), 64'd1);
        check("tmo_cycle", 64'((tmo_q.size() > 0) ? tmo_q[0] : -1), 64'd237);
        check("tmo_latency", 64'(tmo_lat), 64'd16);
        check("tmo_abort", 64'({tmo, req, busy}), 64'b100);
        check("tmo_key_kept", 64'(key), 64'h80040201);
        @(posedge clk); #2;
        check("tmo_pulse_end", 64'(tmo), 64'd0);
        check("tmo_no_kv", 64'(kv_cnt), 64'd1);
        wait_kv(2, 300);
        check("tmo_restart", 64'((start_q.size() > 2) ? start_q[2] : -1), 64'd300);
        check_frame(29, pat, 8'h8F);

        // Snapshot isolation and display-off control byte
        disp = 1'b0; bright = 3'd3;
        do_reset();
        n = 0;
        while (log_cnt < 6 && n < 300) begin @(posedge clk); #2; n++; end
        seg = '1;
        wait_kv(1, 300);
        check_frame(0, pat, 8'h83);
        wait_kv(2, 300);
        check("next_seg0", 64'({log_rd[26], log_last[26], log_dat[26]}), 64'({2'b00, 8'hFF}));
        check("next_ctrl", 64'({log_rd[42], log_last[42], log_dat[42]}), 64'({2'b01, 8'h83}));
        seg = pat; disp = 1'b1; bright = 3'd7;

        // Reset during key read, then a full frame with clock enable at 50%
        en_toggle = 1;
        do_reset();
        n = 0;
        while (fpos < 21 && n < 800) begin @(posedge clk); #2; n++; end
        check("reach_krd", 64'(fpos >= 21), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out", 64'({req, rd, last, dat, key, kv, busy, tmo}), 64'd0);
        repeat (4) @(posedge clk);
        #2;
        check("midrst_no_kv", 64'(kv_cnt), 64'd0);
        do_reset();
        wait_kv(1, 800);
        check("en_start", 64'((start_q.size() > 0) ? start_q[0] : -1), 64'd100);
        check("en_kv_cycle", 64'((kv_q.size() > 0) ? kv_q[0] : -1), 64'd196);
        check("en_key", 64'(key), 64'h80040201);
        check_frame(0, pat, 8'h8F);
        repeat (10) @(posedge clk);
        #2;
        check("en_kv_single", 64'(kv_cnt), 64'd1);
        en_toggle = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
